// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM device-side responder: command pins, mode
// register fields, error flag indices and burst sequencing helpers.
package sdram_pkg;

  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE       = 4'b0011;
  localparam logic [3:0] CMD_WRITE        = 4'b0100;
  localparam logic [3:0] CMD_READ         = 4'b0101;
  localparam logic [3:0] CMD_BURST_TERM   = 4'b0110;
  localparam logic [3:0] CMD_NOP          = 4'b0111;

  localparam int MODE_BL_LSB = 0;
  localparam int MODE_CL_LSB = 4;
  localparam int MODE_WB_BIT = 9;
  localparam int A_AP_BIT    = 10;

  localparam int ERR_INIT   = 0;
  localparam int ERR_CLOSED = 1;
  localparam int ERR_OPEN   = 2;
  localparam int ERR_TIMING = 3;

  typedef enum logic [2:0] {
    BL_1 = 3'd0,
    BL_2 = 3'd1,
    BL_4 = 3'd2,
    BL_8 = 3'd3
  } bl_e;

  // B_WAIT covers the extra CAS cycle when CL=3.
  typedef enum logic [1:0] {
    B_IDLE,
    B_WAIT,
    B_READ,
    B_WRITE
  } bst_e;

  // Index of the last beat; also the wrap mask for the column low bits.
  function automatic logic [2:0] burst_last(input logic [2:0] bl_field);
    case (bl_field)
      BL_2:    burst_last = 3'd1;
      BL_4:    burst_last = 3'd3;
      BL_8:    burst_last = 3'd7;
      default: burst_last = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_resp_mem.sv
// Single-port backing RAM, 2^AW x 16, byte write enables, registered read.
module sdram_resp_mem #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic [AW-1:0] addr,
  input  logic [1:0]    we,
  input  logic [15:0]   wdata,
  output logic [15:0]   rdata
);

  logic [15:0] mem [0:(1<<AW)-1];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sdram_responder.sv
// Device-side SDR SDRAM model: decodes controller commands, tracks banks and
// mode, serves bursts from on-chip RAM. Timing checks under SDRAM_RESPONDER_TIMING_CHK_EN.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int TRCD   = 2,
  parameter int TRP    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs_n,
  input  logic        ras_n,
  input  logic        cas_n,
  input  logic        we_n,
  input  logic [1:0]  ba,
  input  logic [12:0] a,
  input  logic        dqml,
  input  logic        dqmh,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic [12:0] mode_reg,
  output logic        initialized,
  output logic [3:0]  err
);

  logic [3:0]  cmd;
  logic [12:0] mode_q, mode_d;
  logic        init_q, init_d;
  logic [3:0]  err_q, err_d;
  logic [3:0]  open_q, open_d;
  logic [12:0] row_q [4];
  logic [12:0] row_d [4];
  bst_e        bst_q, bst_d;
  logic [1:0]  bank_q, bank_d;
  logic [8:0]  col_q, col_d;
  logic [2:0]  beat_q, beat_d, last_q, last_d;
  logic        ap_q, ap_d;
  logic        dq_oe_q, dq_oe_d;

  logic [MEM_AW-1:0] mem_addr;
  logic [1:0]        mem_we;
  logic [15:0]       mem_rdata;
  logic              timing_err;

  logic [2:0] cl, rd_last, wr_last;
  logic [8:0] beat_col;
  logic       beat_now, last_beat, rw_ok, intr;

  assign cmd       = {cs_n, ras_n, cas_n, we_n};
  assign cl        = mode_q[MODE_CL_LSB +: 3];
  assign rd_last   = burst_last(mode_q[MODE_BL_LSB +: 3]);
  assign wr_last   = mode_q[MODE_WB_BIT] ? 3'd0 : rd_last;
  assign beat_col  = (col_q & ~{6'd0, last_q}) | ((col_q + {6'd0, beat_q}) & {6'd0, last_q});
  assign beat_now  = (bst_q == B_READ) || (bst_q == B_WRITE);
  assign last_beat = (beat_q == last_q);
  assign rw_ok     = ((cmd == CMD_READ) || (cmd == CMD_WRITE)) && init_q && open_q[ba];
  assign intr      = (bst_q != B_IDLE) &&
                     (rw_ok || (cmd == CMD_BURST_TERM) ||
                      ((cmd == CMD_PRECHARGE) && (a[A_AP_BIT] || (ba == bank_q))));

  if (TRCD < 1 || TRP < 1) begin : g_bad_timing
    $error("TRCD and TRP must be at least 1");
  end

  always_comb begin
    mode_d   = mode_q;
    init_d   = init_q;
    err_d    = err_q;
    open_d   = open_q;
    row_d    = row_q;
    bst_d    = bst_q;
    bank_d   = bank_q;
    col_d    = col_q;
    beat_d   = beat_q;
    last_d   = last_q;
    ap_d     = ap_q;
    dq_oe_d  = 1'b0;
    mem_addr = MEM_AW'({bank_q, row_q[bank_q], beat_col});
    mem_we   = 2'b00;

    if (bst_q == B_WAIT) bst_d = B_READ;
    // The beat due at this edge still happens even if a command ends the burst.
    if (beat_now) begin
      if (bst_q == B_READ) dq_oe_d = 1'b1;
      else                 mem_we  = ~{dqmh, dqml};
      if (last_beat) begin
        bst_d = B_IDLE;
        if (ap_q && !intr) open_d[bank_q] = 1'b0;
      end else begin
        beat_d = beat_q + 3'd1;
      end
    end
    if (intr) bst_d = B_IDLE;
    if (timing_err) err_d[ERR_TIMING] = 1'b1;

    case (cmd)
      CMD_LOAD_MODE: begin
        mode_d = a;
        if ((a[MODE_CL_LSB +: 3] == 3'd2) || (a[MODE_CL_LSB +: 3] == 3'd3)) begin
          init_d = 1'b1;
        end else begin
          init_d          = 1'b0;
          err_d[ERR_INIT] = 1'b1;
        end
      end
      CMD_ACTIVE: begin
        if (open_q[ba]) err_d[ERR_OPEN] = 1'b1;
        row_d[ba]  = a;
        open_d[ba] = 1'b1;
      end
      CMD_PRECHARGE: begin
        if (a[A_AP_BIT]) open_d     = 4'b0000;
        else             open_d[ba] = 1'b0;
      end
      CMD_AUTO_REFRESH: begin
        if (|open_q) err_d[ERR_OPEN] = 1'b1;
      end
      CMD_READ, CMD_WRITE: begin
        if (!init_q) begin
          err_d[ERR_INIT] = 1'b1;
        end else if (!open_q[ba]) begin
          err_d[ERR_CLOSED] = 1'b1;
        end else begin
          bank_d = ba;
          col_d  = a[8:0];
          beat_d = 3'd0;
          ap_d   = a[A_AP_BIT];
          if (cmd == CMD_READ) begin
            last_d = rd_last;
            bst_d  = (cl == 3'd3) ? B_WAIT : B_READ;
          end else begin
            // First write beat goes straight from the pins and owns the RAM port.
            last_d   = wr_last;
            beat_d   = 3'd1;
            mem_addr = MEM_AW'({ba, row_q[ba], a[8:0]});
            mem_we   = ~{dqmh, dqml};
            dq_oe_d  = 1'b0;
            if (wr_last == 3'd0) begin
              bst_d = B_IDLE;
              if (a[A_AP_BIT]) open_d[ba] = 1'b0;
            end else begin
              bst_d = B_WRITE;
            end
          end
        end
      end
      default: ;
    endcase
  end

`ifdef SDRAM_RESPONDER_TIMING_CHK_EN
  logic [3:0] tcnt_q [4];
  logic [3:0] tcnt_d [4];
  logic [3:0] pre_q, pre_d;

  // tcnt counts cycles since the bank's last ACTIVE/PRECHARGE; pre marks which.
  always_comb begin
    timing_err = 1'b0;
    if ((cmd == CMD_ACTIVE) && pre_q[ba] && (({1'b0, tcnt_q[ba]} + 5'd1) < 5'(TRP)))
      timing_err = 1'b1;
    if (rw_ok && (({1'b0, tcnt_q[ba]} + 5'd1) < 5'(TRCD)))
      timing_err = 1'b1;
  end

  always_comb begin
    pre_d = pre_q;
    for (int b = 0; b < 4; b++) begin
      tcnt_d[b] = (tcnt_q[b] == 4'hF) ? tcnt_q[b] : tcnt_q[b] + 4'd1;
      if (open_q[b] && !open_d[b]) begin
        tcnt_d[b] = 4'd0;
        pre_d[b]  = 1'b1;
      end
    end
    if (cmd == CMD_ACTIVE) begin
      tcnt_d[ba] = 4'd0;
      pre_d[ba]  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q <= '{default: 4'hF};
      pre_q  <= 4'b0000;
    end else begin
      tcnt_q <= tcnt_d;
      pre_q  <= pre_d;
    end
  end
`else
  assign timing_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q  <= '0;
      init_q  <= 1'b0;
      err_q   <= 4'b0000;
      open_q  <= 4'b0000;
      row_q   <= '{default: '0};
      bst_q   <= B_IDLE;
      bank_q  <= 2'd0;
      col_q   <= 9'd0;
      beat_q  <= 3'd0;
      last_q  <= 3'd0;
      ap_q    <= 1'b0;
      dq_oe_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      init_q  <= init_d;
      err_q   <= err_d;
      open_q  <= open_d;
      row_q   <= row_d;
      bst_q   <= bst_d;
      bank_q  <= bank_d;
      col_q   <= col_d;
      beat_q  <= beat_d;
      last_q  <= last_d;
      ap_q    <= ap_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  sdram_resp_mem #(.AW(MEM_AW)) u_mem (
    .clk   (clk),
    .addr  (mem_addr),
    .we    (mem_we),
    .wdata (dq_in),
    .rdata (mem_rdata)
  );

  assign dq_out      = dq_oe_q ? mem_rdata : 16'h0000;
  assign dq_oe       = dq_oe_q;
  assign mode_reg    = mode_q;
  assign initialized = init_q;
  assign err         = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: stimulus pushes expected read beats
// (data + edge number) into a queue; a negedge monitor pops and compares.
module tb_sdram_responder;
  import sdram_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        dqml, dqmh;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic [12:0] mode_reg;
  logic        initialized;
  logic [3:0]  err;

`ifdef SDRAM_RESPONDER_TIMING_CHK_EN
  localparam logic TE = 1'b1;
`else
  localparam logic TE = 1'b0;
`endif

  sdram_responder dut (
    .clk         (clk),
    .reset       (reset),
    .cs_n        (cs_n),
    .ras_n       (ras_n),
    .cas_n       (cas_n),
    .we_n        (we_n),
    .ba          (ba),
    .a           (a),
    .dqml        (dqml),
    .dqmh        (dqmh),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .mode_reg    (mode_reg),
    .initialized (initialized),
    .err         (err)
  );

  // clock / edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard
  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          t0 = 0;
  logic [15:0] mon_d;
  int          mon_c;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [15:0] d, input int at);
    exp_q.push_back(d);
    exp_cyc_q.push_back(at);
  endtask

  always @(negedge clk) begin
    if (dq_oe === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_beat: dq_out %h at edge %0d, no beat expected", dq_out, cyc);
      end else begin
        mon_d = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if (dq_out !== mon_d || cyc != mon_c) begin
          miscompares++;
          $display("FAIL read_beat: got %h at edge %0d expected %h at edge %0d",
                   dq_out, cyc, mon_d, mon_c);
        end
      end
    end else if (exp_cyc_q.size() > 0 && exp_cyc_q[0] <= cyc) begin
      vectors++;
      miscompares++;
      mon_d = exp_q.pop_front();
      mon_c = exp_cyc_q.pop_front();
      $display("FAIL missing_beat: dq_oe low at edge %0d expected %h at edge %0d", cyc, mon_d, mon_c);
    end
  end

  // drivers: each command is applied at a negedge and sampled at the next posedge (edge t0)
  task automatic do_cmd(input logic [3:0] c, input logic [1:0] b, input logic [12:0] addr,
                        input logic [15:0] d = 16'h0000, input logic mh = 1'b0, input logic ml = 1'b0);
    @(negedge clk);
    {cs_n, ras_n, cas_n, we_n} = c;
    ba    = b;
    a     = addr;
    dq_in = d;
    dqmh  = mh;
    dqml  = ml;
    t0    = cyc + 1;
  endtask

  task automatic nop(input int n);
    repeat (n) do_cmd(CMD_NOP, 2'd0, 13'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int tr;
    {cs_n, ras_n, cas_n, we_n} = CMD_NOP;
    ba = 2'd0; a = 13'd0; dq_in = 16'h0; dqml = 1'b0; dqmh = 1'b0;

    do_reset();
    check("rst_dq_oe", 16'(dq_oe), 16'h0);
    check("rst_dq_out", dq_out, 16'h0);
    check("rst_mode_reg", 16'(mode_reg), 16'h0);
    check("rst_initialized", 16'(initialized), 16'h0);
    check("rst_err", 16'(err), 16'h0);

    // init: CL2, BL1, single write
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h220);
    nop(1);
    check("init_mode_reg", 16'(mode_reg), 16'h0220);
    check("init_initialized", 16'(initialized), 16'h1);
    check("init_err", 16'(err), 16'h0);

    // write/read CL2
    do_cmd(CMD_ACTIVE, 2'd1, 13'd5);
    nop(1);
    do_cmd(CMD_WRITE, 2'd1, 13'd3, 16'hA55A);
    nop(1);
    do_cmd(CMD_READ, 2'd1, 13'd3);
    expect_beat(16'hA55A, t0 + 1);
    nop(3);

    // byte mask
    do_cmd(CMD_WRITE, 2'd1, 13'd8, 16'hFFFF);
    do_cmd(CMD_WRITE, 2'd1, 13'd8, 16'h1234, 1'b1, 1'b0);
    do_cmd(CMD_READ, 2'd1, 13'd8);
    expect_beat(16'hFF34, t0 + 1);
    nop(3);

    // BL4, CL3, preload cols 4..7 with a write burst
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h032);
    nop(1);
    check("bl4_mode_reg", 16'(mode_reg), 16'h0032);
    check("bl4_initialized", 16'(initialized), 16'h1);
    do_cmd(CMD_WRITE, 2'd1, 13'd4, 16'd1);
    do_cmd(CMD_NOP, 2'd0, 13'd0, 16'd2);
    do_cmd(CMD_NOP, 2'd0, 13'd0, 16'd3);
    do_cmd(CMD_NOP, 2'd0, 13'd0, 16'd4);
    nop(1);

    // wrapped burst from col 6
    do_cmd(CMD_READ, 2'd1, 13'd6);
    expect_beat(16'd3, t0 + 2);
    expect_beat(16'd4, t0 + 3);
    expect_beat(16'd1, t0 + 4);
    expect_beat(16'd2, t0 + 5);
    nop(7);

    // burst terminate at T0+3
    do_cmd(CMD_READ, 2'd1, 13'd6);
    tr = t0;
    expect_beat(16'd3, tr + 2);
    expect_beat(16'd4, tr + 3);
    nop(2);
    do_cmd(CMD_BURST_TERM, 2'd0, 13'd0);
    nop(5);

    // READ during CL pipeline drops the first read
    do_cmd(CMD_READ, 2'd1, 13'd6);
    do_cmd(CMD_READ, 2'd1, 13'd4);
    expect_beat(16'd1, t0 + 2);
    expect_beat(16'd2, t0 + 3);
    expect_beat(16'd3, t0 + 4);
    expect_beat(16'd4, t0 + 5);
    nop(7);
    check("clean_err", 16'(err), 16'h0);

    // closed bank, open bank, timing
    do_reset();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h220);
    nop(1);
    do_cmd(CMD_READ, 2'd2, 13'd0);
    nop(2);
    check("err_read_closed", 16'(err), 16'h0002);
    do_cmd(CMD_ACTIVE, 2'd2, 13'd0);
    nop(2);
    do_cmd(CMD_ACTIVE, 2'd2, 13'd0);
    nop(1);
    check("err_active_open", 16'(err), 16'h0006);
    do_cmd(CMD_PRECHARGE, 2'd0, 13'h400);
    nop(1);
    do_cmd(CMD_ACTIVE, 2'd3, 13'd5);
    do_cmd(CMD_READ, 2'd3, 13'd3);
    expect_beat(16'hA55A, t0 + 1);
    nop(3);
    check("err_trcd", 16'(err), 16'({TE, 3'b110}));

    // auto-precharge closes the bank after the burst
    do_reset();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h220);
    nop(1);
    do_cmd(CMD_ACTIVE, 2'd1, 13'd5);
    nop(2);
    do_cmd(CMD_READ, 2'd1, 13'h403);
    expect_beat(16'hA55A, t0 + 1);
    nop(2);
    check("ap_err_before", 16'(err), 16'h0);
    do_cmd(CMD_READ, 2'd1, 13'd3);
    nop(2);
    check("ap_err_after", 16'(err), 16'h0002);

    // reset mid-burst
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h032);
    nop(1);
    do_cmd(CMD_ACTIVE, 2'd1, 13'd5);
    nop(2);
    do_cmd(CMD_READ, 2'd1, 13'd6);
    expect_beat(16'd3, t0 + 2);
    nop(2);
    do_reset();
    check("rst_mid_burst_oe", 16'(dq_oe), 16'h0);

    // uninitialized access, bad CL, refresh with open bank
    do_cmd(CMD_READ, 2'd0, 13'd0);
    nop(2);
    check("err_uninit_read", 16'(err), 16'h0001);
    do_reset();
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h010);
    nop(1);
    check("badcl_initialized", 16'(initialized), 16'h0);
    check("badcl_mode_reg", 16'(mode_reg), 16'h0010);
    check("badcl_err", 16'(err), 16'h0001);
    do_cmd(CMD_LOAD_MODE, 2'd0, 13'h220);
    nop(1);
    do_cmd(CMD_ACTIVE, 2'd0, 13'd0);
    nop(1);
    do_cmd(CMD_AUTO_REFRESH, 2'd0, 13'd0);
    nop(1);
    check("refresh_err", 16'(err), 16'h0005);
    check("refresh_initialized", 16'(initialized), 16'h1);

    nop(3);
    check("exp_queue_drained", 16'(exp_q.size()), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
